dds_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer for the DDS excitation source in the impedance front end. It steps the DDS frequency word through a linear multi-frequency sweep. At each point it holds a settle interval, then a measurement window, and flags that window so the downstream demodulator/ADC integrator only accumulates on settled excitation. It drives the `fre_w`/`pha_w` inputs of the `dds` instance directly.

---
 rtl/dds_sweep_pkg.sv | 18 +
 rtl/dds_sweep_ctrl_if.sv | 40 ++++
 rtl/dds_sweep_ctrl_down_cnt.sv | 22 ++
 rtl/dds_sweep_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_sweep_pkg.sv
// Shared definitions for the DDS frequency-sweep sequencer.
// - state_e: sequencer state encoding (IDLE=0, SETTLE=1, MEASURE=2, DONE=3).
// - Default DDS word widths, shared with the dds core so both sides agree.
package dds_sweep_pkg;

  localparam int DEF_FWORD_WIDTH = 28;
  localparam int DEF_PWORD_WIDTH = 10;
  localparam int DEF_CNT_WIDTH   = 16;
  localparam int DEF_STEP_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Sweep control/status bundle between a sweep requester and dds_sweep_ctrl.
// - master: drives start/abort and sweep config, observes DDS words and flags.
// - slave : the sequencer side.
interface dds_sweep_ctrl_if
  import dds_sweep_pkg::*;
#(
  parameter int Fword_width = DEF_FWORD_WIDTH,
  parameter int Pword_width = DEF_PWORD_WIDTH,
  parameter int Cnt_width   = DEF_CNT_WIDTH,
  parameter int Step_width  = DEF_STEP_WIDTH
);
  logic                   start;
  logic                   abort;
  logic [Fword_width-1:0] start_fre;
  logic [Fword_width-1:0] step_fre;
  logic [Step_width-1:0]  num_steps;
  logic [Cnt_width-1:0]   settle_cycles;
  logic [Cnt_width-1:0]   dwell_cycles;
  logic [Pword_width-1:0] pha_cfg;

  logic [Fword_width-1:0] fre_w;
  logic [Pword_width-1:0] pha_w;
  logic                   meas_valid;
  logic                   step_done;
  logic [Step_width-1:0]  step_idx;
  logic                   busy;
  logic                   done;

  modport master (
    output start, abort, start_fre, step_fre, num_steps,
           settle_cycles, dwell_cycles, pha_cfg,
    input  fre_w, pha_w, meas_valid, step_done, step_idx, busy, done
  );

  modport slave (
    input  start, abort, start_fre, step_fre, num_steps,
           settle_cycles, dwell_cycles, pha_cfg,
    output fre_w, pha_w, meas_valid, step_done, step_idx, busy, done
  );
endinterface

// File: rtl/dds_sweep_ctrl_down_cnt.sv
// sweep_down_cnt: loadable down-counter shared by the settle and dwell
// intervals. Load with (length - 1); zero marks the final cycle of the
// interval. Holds at zero until reloaded.
// Ports: clk, rst (sync, active high), load, load_val, cnt, zero.
module sweep_down_cnt #(
  parameter int Cnt_width = 16
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [Cnt_width-1:0] load_val,
  output logic [Cnt_width-1:0] cnt,
  output logic                 zero
);
  always_ff @(posedge clk) begin
    if (rst)            cnt <= '0;
    else if (load)      cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear multi-point frequency sweep for the DDS excitation.
// Each point holds settle_cycles of settle, then max(dwell_cycles,1) cycles
// of measurement window (meas_valid high), stepping fre_w by step_fre.
// Ports: clk, rst (sync, active high), bus (dds_sweep_ctrl_if.slave) carrying
// start/abort, sweep config, and the registered DDS words and status flags.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int Fword_width = DEF_FWORD_WIDTH,
  parameter int Pword_width = DEF_PWORD_WIDTH,
  parameter int Cnt_width   = DEF_CNT_WIDTH,
  parameter int Step_width  = DEF_STEP_WIDTH
)(
  input  logic           clk,
  input  logic           rst,
  dds_sweep_ctrl_if.slave bus
);
  state_e                 state;
  logic [Fword_width-1:0] fre_q;
  logic [Pword_width-1:0] pha_q;
  logic                   meas_q, sd_q, busy_q, done_q;
  logic [Step_width-1:0]  idx_q;

  // Latched sweep config (stored pre-normalised: last index and dwell-1).
  logic [Fword_width-1:0] step_q;
  logic [Step_width-1:0]  last_q;
  logic [Cnt_width-1:0]   settle_q;
  logic [Cnt_width-1:0]   dwell_m1_q;

  logic [Step_width-1:0]  in_last;
  logic [Cnt_width-1:0]   in_dwell_m1;
  logic                   cnt_load, cnt_zero;
  logic [Cnt_width-1:0]   cnt_val, cnt;
  logic                   pt_last;

  // num_steps=0 and dwell_cycles=0 both behave as 1.
  assign in_last     = (bus.num_steps    == '0) ? '0 : bus.num_steps - 1'b1;
  assign in_dwell_m1 = (bus.dwell_cycles == '0) ? '0 : bus.dwell_cycles - 1'b1;
  assign pt_last     = (idx_q == last_q);

  // Counter reload on every interval entry; settle of 0 skips straight to
  // loading the dwell length.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: if (bus.start && !bus.abort) begin
        cnt_load = 1'b1;
        cnt_val  = (bus.settle_cycles != '0) ? bus.settle_cycles - 1'b1 : in_dwell_m1;
      end
      SETTLE: if (cnt_zero) begin
        cnt_load = 1'b1;
        cnt_val  = dwell_m1_q;
      end
      MEASURE: if (cnt_zero && !pt_last) begin
        cnt_load = 1'b1;
        cnt_val  = (settle_q != '0) ? settle_q - 1'b1 : dwell_m1_q;
      end
      default: ;
    endcase
  end

  sweep_down_cnt #(.Cnt_width(Cnt_width)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // step_done is registered, so it is set one cycle ahead: whenever the next
  // cycle is a MEASURE cycle whose counter will read zero.
  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      state  <= IDLE;
      fre_q  <= '0;
      pha_q  <= '0;
      meas_q <= 1'b0;
      sd_q   <= 1'b0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      if (rst) begin
        step_q     <= '0;
        last_q     <= '0;
        settle_q   <= '0;
        dwell_m1_q <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          fre_q  <= '0;
          pha_q  <= '0;
          meas_q <= 1'b0;
          sd_q   <= 1'b0;
          idx_q  <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            step_q     <= bus.step_fre;
            last_q     <= in_last;
            settle_q   <= bus.settle_cycles;
            dwell_m1_q <= in_dwell_m1;
            fre_q      <= bus.start_fre;
            pha_q      <= bus.pha_cfg;
            busy_q     <= 1'b1;
            if (bus.settle_cycles != '0) begin
              state <= SETTLE;
            end else begin
              state  <= MEASURE;
              meas_q <= 1'b1;
              sd_q   <= (in_dwell_m1 == '0);
            end
          end
        end
        SETTLE: if (cnt_zero) begin
          state  <= MEASURE;
          meas_q <= 1'b1;
          sd_q   <= (dwell_m1_q == '0);
        end
        MEASURE: begin
          if (cnt_zero) begin
            sd_q <= 1'b0;
            if (pt_last) begin
              state  <= DONE;
              meas_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              fre_q <= fre_q + step_q;
              idx_q <= idx_q + 1'b1;
              if (settle_q != '0) begin
                state  <= SETTLE;
                meas_q <= 1'b0;
              end else begin
                state  <= MEASURE;
                meas_q <= 1'b1;
                sd_q   <= (dwell_m1_q == '0);
              end
            end
          end else begin
            sd_q <= (cnt == Cnt_width'(1));
          end
        end
        DONE: begin
          state  <= IDLE;
          fre_q  <= '0;
          pha_q  <= '0;
          idx_q  <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fre_w      = fre_q;
  assign bus.pha_w      = pha_q;
  assign bus.meas_valid = meas_q;
  assign bus.step_done  = sd_q;
  assign bus.step_idx   = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: table of directed sweeps, randomized sweeps,
// and hand sequences for abort, start-while-busy and reset mid-sweep.
// Expected per-cycle outputs come from a closed-form timeline model.
module tb_dds_sweep_ctrl;
  localparam int FW = 28, PW = 10, CW = 16, SW = 8;

  typedef struct packed {
    logic [FW-1:0] start_fre;
    logic [FW-1:0] step_fre;
    logic [SW-1:0] n;
    logic [CW-1:0] s;
    logic [CW-1:0] d;
    logic [PW-1:0] pha;
  } cfg_t;

  typedef struct packed {
    logic [FW-1:0] fre;
    logic [PW-1:0] pha;
    logic          meas;
    logic          sd;
    logic [SW-1:0] idx;
    logic          busy;
    logic          done;
  } out_t;

  typedef struct {
    cfg_t          c;
    int            exp_done;
    logic [FW-1:0] exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.Fword_width(FW), .Pword_width(PW),
                      .Cnt_width(CW), .Step_width(SW)) bus ();

  dds_sweep_ctrl #(.Fword_width(FW), .Pword_width(PW),
                   .Cnt_width(CW), .Step_width(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Timeline model: cycle k = 1 is the first cycle after the start edge.
  // Point p occupies cycles p*P+1 .. (p+1)*P with P = S + max(D,1); the
  // first S of those settle, the rest measure; done follows the last point.
  function automatic int period(cfg_t c);
    return int'(c.s) + ((c.d == '0) ? 1 : int'(c.d));
  endfunction

  function automatic int npts(cfg_t c);
    return (c.n == '0) ? 1 : int'(c.n);
  endfunction

  function automatic out_t model(cfg_t c, int k, int abort_k);
    out_t o;
    int p, total, pt, r;
    o = '0;
    p = period(c);
    total = npts(c) * p;
    if (abort_k > 0 && k > abort_k) return o;
    if (k >= 1 && k <= total) begin
      pt     = (k - 1) / p;
      r      = (k - 1) % p;
      o.fre  = c.start_fre + c.step_fre * FW'(pt);
      o.pha  = c.pha;
      o.meas = (r >= int'(c.s));
      o.sd   = (r == p - 1);
      o.idx  = SW'(pt);
      o.busy = 1'b1;
    end else if (k == total + 1) begin
      o.fre  = c.start_fre + c.step_fre * FW'(npts(c) - 1);
      o.pha  = c.pha;
      o.idx  = SW'(npts(c) - 1);
      o.busy = 1'b1;
      o.done = 1'b1;
    end
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.fre  = bus.fre_w;
    o.pha  = bus.pha_w;
    o.meas = bus.meas_valid;
    o.sd   = bus.step_done;
    o.idx  = bus.step_idx;
    o.busy = bus.busy;
    o.done = bus.done;
    return o;
  endfunction

  task automatic check_out(input string name, input int k, input out_t exp);
    out_t got;
    got = sample();
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s k=%0d got fre=%h pha=%h mv=%b sd=%b idx=%0d busy=%b done=%b want fre=%h pha=%h mv=%b sd=%b idx=%0d busy=%b done=%b",
               name, k, got.fre, got.pha, got.meas, got.sd, got.idx, got.busy, got.done,
               exp.fre, exp.pha, exp.meas, exp.sd, exp.idx, exp.busy, exp.done);
    end
  endtask

  task automatic drive_cfg(input cfg_t c);
    bus.start_fre     = c.start_fre;
    bus.step_fre      = c.step_fre;
    bus.num_steps     = c.n;
    bus.settle_cycles = c.s;
    bus.dwell_cycles  = c.d;
    bus.pha_cfg       = c.pha;
  endtask

  // Runs one sweep, comparing every cycle. abort_k/poke_k (0 = off) assert
  // abort / a start with scrambled config at the end of that cycle.
  task automatic run_sweep(input string name, input vec_t v, input int abort_k, input int poke_k);
    int len, done_k;
    logic [FW-1:0] last_fre;
    out_t got;
    len = npts(v.c) * period(v.c) + 3;
    done_k = 0;
    last_fre = '0;
    @(negedge clk);
    drive_cfg(v.c);
    bus.abort = 1'b0;
    bus.start = 1'b1;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check_out(name, k, model(v.c, k, abort_k));
      got = sample();
      if (got.done && done_k == 0) begin
        done_k   = k;
        last_fre = got.fre;
      end
      if (k == abort_k) bus.abort = 1'b1;
      if (k == poke_k) begin
        bus.start         = 1'b1;
        bus.start_fre     = ~v.c.start_fre;
        bus.step_fre      = FW'($urandom);
        bus.num_steps     = v.c.n + 8'd3;
        bus.settle_cycles = v.c.s + 16'd2;
        bus.dwell_cycles  = v.c.d + 16'd5;
        bus.pha_cfg       = ~v.c.pha;
      end
    end
    bus.abort = 1'b0;
    nvec++;
    if (done_k != v.exp_done) begin
      nerr++;
      $display("FAIL %s done_cycle got=%0d want=%0d", name, done_k, v.exp_done);
    end
    if (v.exp_done != 0) begin
      nvec++;
      if (last_fre !== v.exp_last) begin
        nerr++;
        $display("FAIL %s last_fre got=%h want=%h", name, last_fre, v.exp_last);
      end
    end
  endtask

  vec_t tbl[6];
  vec_t vb, vr;
  out_t idle_o;

  initial begin
    idle_o = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    drive_cfg('0);

    // {start, step, N, S, D, pha}, done cycle, fre at done
    tbl[0] = '{'{28'h0100000, 28'h0010000, 8'd3,   16'd4, 16'd8, 10'h155}, 37,  28'h0120000};
    tbl[1] = '{'{28'h0000ABC, 28'h0000100, 8'd2,   16'd0, 16'd0, 10'h3FF}, 3,   28'h0000BBC};
    tbl[2] = '{'{28'hFFFFFF0, 28'h0000020, 8'd2,   16'd2, 16'd3, 10'h001}, 11,  28'h0000010};
    tbl[3] = '{'{28'h1234567, 28'h0000001, 8'd0,   16'd3, 16'd2, 10'h0AA}, 6,   28'h1234567};
    tbl[4] = '{'{28'h0000001, 28'h0000002, 8'd1,   16'd1, 16'd1, 10'h200}, 3,   28'h0000001};
    tbl[5] = '{'{28'h0000000, 28'h0000010, 8'd255, 16'd0, 16'd1, 10'h123}, 256, 28'h0000FE0};

    // Reset state
    repeat (3) @(negedge clk);
    check_out("reset", 0, idle_o);
    rst = 1'b0;

    foreach (tbl[i]) run_sweep($sformatf("tbl%0d", i), tbl[i], 0, 0);

    // Abort in the 3rd MEASURE cycle of point 1 (P=12, S=4 -> k=19)
    vb = tbl[0];
    vb.exp_done = 0;
    run_sweep("abort", vb, 12 + 4 + 3, 0);

    // start during SETTLE with altered config: sweep unchanged
    run_sweep("start_busy", tbl[0], 0, 2);

    // start and abort together in IDLE: nothing starts
    @(negedge clk);
    drive_cfg(tbl[0].c);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check_out("start_abort", k, idle_o);
    end

    // Reset mid-sweep, then a sweep with N=0 runs exactly one point
    @(negedge clk);
    drive_cfg(tbl[0].c);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_out("rst_mid", 0, idle_o);
    rst = 1'b0;
    @(negedge clk);
    check_out("rst_idle", 1, idle_o);
    run_sweep("after_rst", tbl[3], 0, 0);

    // Randomized sweeps, some with abort or busy-start injection
    for (int t = 0; t < 25; t++) begin
      int total, ab, pk;
      vr.c.start_fre = FW'($urandom);
      vr.c.step_fre  = FW'($urandom);
      vr.c.n         = SW'($urandom_range(0, 6));
      vr.c.s         = CW'($urandom_range(0, 5));
      vr.c.d         = CW'($urandom_range(0, 5));
      vr.c.pha       = PW'($urandom);
      total = npts(vr.c) * period(vr.c);
      ab = 0;
      pk = 0;
      case ($urandom_range(0, 2))
        1: ab = $urandom_range(1, total + 1);
        2: pk = $urandom_range(1, total + 1);
        default: ;
      endcase
      vr.exp_done = (ab > 0 && ab <= total) ? 0 : total + 1;
      vr.exp_last = vr.c.start_fre + vr.c.step_fre * FW'(npts(vr.c) - 1);
      run_sweep($sformatf("rand%0d", t), vr, ab, pk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
